wb_pipe_reg: RTL and testbench

- Parametrised MEM/WB pipeline stage register carrying the writeback bundle: GPR target, GPR data, HI/LO write.
- Successor to the fixed-width MEM/WB latch; adds a valid/ready handshake on both sides, a 2-entry skid buffer and synchronous flush.
- Bubbles are guaranteed never to write the register file or HI/LO.
- Adds a saturating downstream-stall counter for performance monitoring.
- Sits between the MEM stage and the GPR/HI-LO write ports.

---
 rtl/wb_pipe_reg_if.sv | 40 ++++
 rtl/wb_pipe_reg.sv | 132 +++++++++++++
 tb/tb_wb_pipe_reg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pipe_reg_if.sv
// MEM -> WB writeback bundle with valid/ready handshakes on both sides.
interface wb_pipe_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  // MEM-stage side
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  // Writeback side
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] wb_wd;
  logic                  wb_wreg;
  logic [DATA_W-1:0]     wb_wdata;
  logic                  wb_whilo;
  logic [DATA_W-1:0]     wb_hi;
  logic [DATA_W-1:0]     wb_lo;

  // Environment view: MEM stage produces bundles, writeback consumes them
  modport master (
    output in_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output out_ready,
    input  in_ready,
    input  out_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );

  // Pipeline register view
  modport slave (
    input  in_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  out_ready,
    output in_ready,
    output out_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: main entry plus one skid entry, synchronous flush,
// saturating downstream-stall counter. Bubbles never assert wb_wreg/wb_whilo.
module wb_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  wb_pipe_reg_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
  } payload_t;

  // Encoding is {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state_q, state_d;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   in_pl;
  logic       in_ready_q;
  logic       wreg_q;
  logic       whilo_q;
  logic       accept_c;
  logic       drain_c;

  assign in_pl = '{wd:    bus.mem_wd,
                   wreg:  bus.mem_wreg,
                   wdata: bus.mem_wdata,
                   whilo: bus.mem_whilo,
                   hi:    bus.mem_hi,
                   lo:    bus.mem_lo};

  assign accept_c = bus.in_valid & in_ready_q;
  assign drain_c  = state_q[0] & bus.out_ready;

  // Next state and entry loads; flush empties both entries and drops the input
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d = ST_ONE;
            main_d  = in_pl;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            main_d = in_pl;
          end else if (drain_c) begin
            state_d = ST_EMPTY;
          end else if (accept_c) begin
            state_d = ST_FULL;
            skid_d  = in_pl;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide with the drain
          if (drain_c) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and registered handshake/qualified-enable outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      wreg_q     <= 1'b0;
      whilo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= ~state_d[1];
      wreg_q     <= main_d.wreg & state_d[0];
      whilo_q    <= main_d.whilo & state_d[0];
    end
  end

  // Payload entries; next values equal current ones unless an entry loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Saturating count of cycles the writeback side holds off a valid bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state_q[0] && !bus.out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = state_q[0];
  assign bus.wb_wd     = main_q.wd;
  assign bus.wb_wreg   = wreg_q;
  assign bus.wb_wdata  = main_q.wdata;
  assign bus.wb_whilo  = whilo_q;
  assign bus.wb_hi     = main_q.hi;
  assign bus.wb_lo     = main_q.lo;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg (CNT_W=4 so saturation is reachable).
module tb_wb_pipe_reg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass;
  int n_total;

  wb_pipe_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  wb_pipe_reg #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic whilo,
                       input logic [31:0] hi, input logic [31:0] lo);
    bus.in_valid  = v;
    bus.mem_wd    = wd;
    bus.mem_wreg  = wreg;
    bus.mem_wdata = wdata;
    bus.mem_whilo = whilo;
    bus.mem_hi    = hi;
    bus.mem_lo    = lo;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    flush   = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_wb_wd",     64'(bus.wb_wd),     64'd0);
    check("rst_wb_wreg",   64'(bus.wb_wreg),   64'd0);
    check("rst_wb_hi",     64'(bus.wb_hi),     64'd0);
    check("rst_stall",     64'(stall_cnt),     64'd0);
    rst = 1'b1;

    // Streaming: four back-to-back bundles, each visible the cycle after accept
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 1'b1, 32'h11111111 * 32'(k), 1'b0, 32'h0, 32'h0);
      tick();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_wd",    64'(bus.wb_wd),     64'(k));
      check("stream_wdata", 64'(bus.wb_wdata),  64'(32'h11111111 * 32'(k)));
      check("stream_ready", 64'(bus.in_ready),  64'd1);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drained", 64'(bus.out_valid), 64'd0);
    check("stream_stall",   64'(stall_cnt),     64'd0);

    // Backpressure: 5 in main, 6 into skid, 7 held off
    drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
    tick();
    check("bp_wd5", 64'(bus.wb_wd), 64'd5);
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 32'h0, 32'h0);
    tick();
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold_wd5",   64'(bus.wb_wd),    64'd5);
    check("bp_stall1",     64'(stall_cnt),    64'd1);
    drive(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 32'h0, 32'h0);
    tick();
    check("bp_still_full", 64'(bus.in_ready), 64'd0);
    check("bp_stall2",     64'(stall_cnt),    64'd2);
    bus.out_ready = 1'b1;
    tick();
    check("bp_wd6",       64'(bus.wb_wd),    64'd6);
    check("bp_wdata6",    64'(bus.wb_wdata), 64'h66);
    check("bp_ready_back",64'(bus.in_ready), 64'd1);
    tick();
    check("bp_wd7",    64'(bus.wb_wd),    64'd7);
    check("bp_wdata7", 64'(bus.wb_wdata), 64'h77);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check("bp_empty",       64'(bus.out_valid), 64'd0);
    check("bp_stall_final", 64'(stall_cnt),     64'd2);

    // Bubble safety: enables must drop while payload holds its last value
    drive(1'b1, 5'd8, 1'b1, 32'h88, 1'b1, 32'hC0FFEE00, 32'h0BADF00D);
    tick();
    check("bub_wreg_on",  64'(bus.wb_wreg),  64'd1);
    check("bub_whilo_on", 64'(bus.wb_whilo), 64'd1);
    check("bub_hi",       64'(bus.wb_hi),    64'hC0FFEE00);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_valid", 64'(bus.out_valid), 64'd0);
      check("bub_wreg",  64'(bus.wb_wreg),   64'd0);
      check("bub_whilo", 64'(bus.wb_whilo),  64'd0);
      check("bub_lo_held", 64'(bus.wb_lo),   64'h0BADF00D);
    end

    // Flush in FULL with a simultaneous offer and no drain
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 32'hAA, 1'b0, 32'h0, 32'h0);
    tick();
    check("fl_full",   64'(bus.in_ready), 64'd0);
    check("fl_stall3", 64'(stall_cnt),    64'd3);
    flush = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 32'hBB, 1'b1, 32'h0, 32'h0);
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_ready", 64'(bus.in_ready),  64'd1);
    check("fl_wreg",  64'(bus.wb_wreg),   64'd0);
    // The flush cycle itself was blocked, so it counts; the flush does not clear
    check("fl_stall", 64'(stall_cnt),     64'd4);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("fl_nothing", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 5'd12, 1'b1, 32'hCC, 1'b0, 32'h0, 32'h0);
    tick();
    check("fl_next_valid", 64'(bus.out_valid), 64'd1);
    check("fl_next_wd",    64'(bus.wb_wd),     64'd12);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();

    // Asynchronous reset between edges while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd13, 1'b1, 32'hDD, 1'b1, 32'hAAAAAAAA, 32'h55555555);
    tick();
    drive(1'b1, 5'd14, 1'b1, 32'hEE, 1'b1, 32'h12345678, 32'h87654321);
    tick();
    check("ar_full",  64'(bus.in_ready), 64'd0);
    check("ar_hi_pre",64'(bus.wb_hi),    64'hAAAAAAAA);
    #1;
    rst = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_wreg",  64'(bus.wb_wreg),   64'd0);
    check("ar_whilo", 64'(bus.wb_whilo),  64'd0);
    check("ar_hi",    64'(bus.wb_hi),     64'd0);
    check("ar_lo",    64'(bus.wb_lo),     64'd0);
    check("ar_ready", 64'(bus.in_ready),  64'd1);
    check("ar_stall", 64'(stall_cnt),     64'd0);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;

    // Counter saturation with 4-bit counter
    drive(1'b1, 5'd15, 1'b1, 32'hF0, 1'b0, 32'h0, 32'h0);
    tick();
    check("sat_start", 64'(stall_cnt), 64'd0);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_14", 64'(stall_cnt), 64'd14);
    end
    check("sat_20", 64'(stall_cnt), 64'd15);
    tick();
    check("sat_hold", 64'(stall_cnt), 64'd15);
    check("sat_wd",   64'(bus.wb_wd), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
